// File: rtl/md_pkg.sv
// md_pkg: shared opcode encodings, FSM states and latency constants for the HI/LO multiply/divide unit
package md_pkg;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] MULT_CYCLES = 4'd5;
   localparam logic [CNT_W-1:0] DIV_CYCLES  = 4'd10;
   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6,
      MD_RSVD  = 3'd7
   } md_op_e;
   typedef enum logic {S_IDLE, S_RUN} state_e;
endpackage

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit; results are computed at acceptance and committed after a fixed busy latency. Macro MDU_ZERO_DIV_GUARD_EN makes divide-by-zero leave HI/LO untouched.
module mult_div_unit
   import md_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   md_op_e           op;
   logic             mul_sgn, a_neg, b_neg;
   logic [63:0]      prod;
   logic [31:0]      a_mag, b_den, uq, ur, quo, rem;

   assign op      = md_op_e'(md_op);
   assign mul_sgn = op == MD_MULT;
   assign prod    = {{32{mul_sgn & A[31]}}, A} * {{32{mul_sgn & B[31]}}, B};
   assign a_neg   = (op == MD_DIV) & A[31];
   assign b_neg   = (op == MD_DIV) & B[31];
   assign a_mag   = a_neg ? -A : A;
   assign b_den   = (B == '0) ? 32'd1 : (b_neg ? -B : B);
   assign uq      = a_mag / b_den;
   assign ur      = a_mag % b_den;
   assign quo     = (a_neg ^ b_neg) ? -uq : uq;
   assign rem     = a_neg ? -ur : ur;
   assign busy    = state_q == S_RUN;
   assign HI      = hi_q;
   assign LO      = lo_q;

   // next state: count down and commit while running, otherwise accept a new operation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      if (state_q == S_RUN) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == 1) begin
            hi_d    = phi_q;
            lo_d    = plo_q;
            state_d = S_IDLE;
         end
      end else if (start) begin
         case (op)
            MD_MULT, MD_MULTU: begin
               phi_d   = prod[63:32];
               plo_d   = prod[31:0];
               cnt_d   = MULT_CYCLES;
               state_d = S_RUN;
            end
            MD_DIV, MD_DIVU: begin
`ifdef MDU_ZERO_DIV_GUARD_EN
               phi_d   = (B == '0) ? hi_q : rem;
               plo_d   = (B == '0) ? lo_q : quo;
`else
               phi_d   = (B == '0) ? A : rem;
               plo_d   = (B == '0) ? 32'hFFFF_FFFF : quo;
`endif
               cnt_d   = DIV_CYCLES;
               state_d = S_RUN;
            end
            MD_MTHI: hi_d = A;
            MD_MTLO: lo_d = A;
            default: ;
         endcase
      end
   end

   // state registers; reset discards any in-flight result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized scoreboard bench for mult_div_unit against an arithmetic reference model
module tb_mult_div_unit;
   logic        clk = 0, rst_n = 0, start = 0, busy;
   logic [2:0]  md_op = 0;
   logic [31:0] A = 0, B = 0, HI, LO;
   int          checks = 0, errors = 0;
   logic [31:0] m_hi = 0, m_lo = 0;

   typedef struct {
      logic [31:0] hi, lo, old_hi, old_lo;
      int          lat;
   } exp_t;
   exp_t q[$];

   mult_div_unit dut (.clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
                      .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el, output int lat);
      longint x, y, p;
      eh = m_hi; el = m_lo; lat = 0;
      case (op)
         3'd1, 3'd2: begin
            x = (op == 3'd1) ? longint'($signed(a)) : longint'({32'b0, a});
            y = (op == 3'd1) ? longint'($signed(b)) : longint'({32'b0, b});
            p = x * y;
            eh = p[63:32]; el = p[31:0]; lat = 5;
         end
         3'd3, 3'd4: begin
            lat = 10;
            if (b == 0) begin
`ifndef MDU_ZERO_DIV_GUARD_EN
               eh = a; el = 32'hFFFF_FFFF;
`endif
            end else begin
               x = (op == 3'd3) ? longint'($signed(a)) : longint'({32'b0, a});
               y = (op == 3'd3) ? longint'($signed(b)) : longint'({32'b0, b});
               p = x % y; eh = p[31:0];
               p = x / y; el = p[31:0];
            end
         end
         3'd5: eh = a;
         3'd6: el = a;
         default: ;
      endcase
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el;
      int lat;
      model(op, a, b, eh, el, lat);
      if (lat != 0) q.push_back('{hi: eh, lo: el, old_hi: m_hi, old_lo: m_lo, lat: lat});
      m_hi = eh; m_lo = el;
      @(negedge clk);
      start = 1; md_op = op; A = a; B = b;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check("busy_done", {31'b0, busy}, 32'd0);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      issue(op, a, b);
      if (op inside {3'd1, 3'd2, 3'd3, 3'd4}) wait_idle();
      else begin
         check("imm_busy", {31'b0, busy}, 32'd0);
         check("imm_hi", HI, m_hi);
         check("imm_lo", LO, m_lo);
      end
   endtask

   // monitor: old HI/LO held while busy, commit and latency checked when busy falls
   initial begin
      int   bc;
      logic pb;
      exp_t e;
      bc = 0; pb = 0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            bc = 0; pb = 0;
         end else begin
            if (busy) begin
               bc++;
               if (q.size() > 0) begin
                  check("hold_hi", HI, q[0].old_hi);
                  check("hold_lo", LO, q[0].old_lo);
               end
            end else if (pb) begin
               check("commit_queued", q.size() == 0 ? 32'd0 : 32'd1, 32'd1);
               if (q.size() > 0) begin
                  e = q.pop_front();
                  check("commit_hi", HI, e.hi);
                  check("commit_lo", LO, e.lo);
                  check("busy_len", bc, e.lat);
               end
               bc = 0;
            end
            pb = busy;
         end
      end
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] b;
      #2;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_hi", HI, 32'd0);
      check("rst_lo", LO, 32'd0);
      @(negedge clk); rst_n = 1;
      run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
      check("mult_hi", HI, 32'hFFFF_FFFF);
      check("mult_lo", LO, 32'hFFFF_FFFA);
      run_op(3'd4, 32'd100, 32'd7);
      check("divu_hi", HI, 32'd2);
      check("divu_lo", LO, 32'd14);
      run_op(3'd3, 32'hFFFF_FFF9, 32'd2);
      check("div_hi", HI, 32'hFFFF_FFFF);
      check("div_lo", LO, 32'hFFFF_FFFD);
      run_op(3'd5, 32'h1234_5678, 32'd0);
      check("mthi_hi", HI, 32'h1234_5678);
      run_op(3'd6, 32'hCAFE_F00D, 32'd0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(3'd3, 32'h8000_0007, 32'd0);
      run_op(3'd4, 32'h0000_0123, 32'd0);
      run_op(3'd0, 32'h1111_1111, 32'h2222_2222);
      run_op(3'd7, 32'h3333_3333, 32'h4444_4444);
      // mtlo arriving while a multiply is busy must be dropped
      issue(3'd1, 32'd6, 32'd7);
      @(negedge clk);
      start = 1; md_op = 3'd6; A = 32'd5;
      @(negedge clk);
      start = 0;
      wait_idle();
      check("ignored_mtlo_lo", LO, 32'd42);
      // back-to-back random operations
      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20));
         run_op(op, $urandom, b);
      end
      // reset in the middle of a divide
      issue(3'd4, 32'd1000, 32'd3);
      @(posedge clk); #1;
      @(negedge clk);
      q.delete();
      rst_n = 0;
      #1;
      m_hi = 0; m_lo = 0;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_hi", HI, 32'd0);
      check("midrst_lo", LO, 32'd0);
      @(negedge clk); rst_n = 1;
      repeat (14) @(posedge clk);
      #1;
      check("post_rst_busy", {31'b0, busy}, 32'd0);
      check("post_rst_hi", HI, 32'd0);
      check("post_rst_lo", LO, 32'd0);
      run_op(3'd2, 32'h0001_0000, 32'h0001_0000);
      check("post_rst_mult_hi", HI, 32'd1);
      check("queue_empty", q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port start  in  1  E-stage operation valid; sampled on rising clk.
REQ-004 SHALL have port md_op  in  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved/none.
REQ-005 SHALL have port A  in  32  rs operand, already forwarded.
REQ-006 SHALL have port B  in  32  rt operand, already forwarded.
REQ-007 SHALL have port busy  out  1  multi-cycle operation in flight.
REQ-008 SHALL have port HI  out  32  architectural HI register.
REQ-009 SHALL have port LO  out  32  architectural LO register.

Function
REQ-010 SHALL accept an operation only on an edge where start=1 and busy=0; start while busy=1 is ignored (no state change).
REQ-011 SHALL, on accepting mult/multu, compute the 64-bit signed/unsigned product of A,B into pending registers and load the cycle counter with 5.
REQ-012 SHALL, on accepting div/divu, compute the signed/unsigned quotient to pending LO and remainder to pending HI, and load the counter with 10.
REQ-013 SHALL compute signed division with truncation toward zero; remainder takes the dividend's sign.
REQ-014 SHALL drive busy=1 exactly while counter!=0: busy rises in the cycle after the accepting edge and stays high for 5 (mult) or 10 (div) cycles.
REQ-015 SHALL decrement the counter each edge while non-zero; on the edge where it goes 1->0, SHALL commit pending HI/LO to HI/LO and busy falls that same edge.
REQ-016 SHALL leave HI/LO unchanged from acceptance until commit; readers see old values while busy=1.
REQ-017 SHALL, on accepting mthi (mtlo), write A to HI (LO) at that edge, with no busy assertion.
REQ-018 SHALL treat md_op 0 or 7 with start=1 as no operation.
REQ-019 SHALL have a two-state FSM: IDLE (counter=0) and RUN (counter!=0); IDLE->RUN on accepting mult/multu/div/divu, RUN->IDLE on commit edge.
REQ-020 SHALL allow a new operation to be accepted on the first edge after busy falls (back-to-back with one idle cycle visible at busy).

Reset
REQ-021 SHALL, while rst_n=0, asynchronously clear HI, LO, pending registers and counter to 0; busy=0.
REQ-022 SHALL, on reset mid-operation, discard the in-flight result; HI/LO read 0 after reset.

Configuration
REQ-023 SHALL support macro MDU_ZERO_DIV_GUARD_EN.
REQ-024 With MDU_ZERO_DIV_GUARD_EN defined: div/divu with B=0 SHALL still run 10 busy cycles but commit no change to HI/LO.
REQ-025 Without it: div/divu with B=0 SHALL commit HI=A and LO=32'hFFFF_FFFF.

Structure
REQ-026 SHALL take md_op encodings and latency constants MULT_CYCLES=5, DIV_CYCLES=10 from shared package md_pkg.
REQ-027 SHALL be a single module; no sub-module.

Verification
REQ-028 mult A=32'hFFFF_FFFE(-2), B=3 -> busy high 5 cycles, then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA.
REQ-029 divu A=100, B=7 -> busy high 10 cycles, then HI=2, LO=14; HI/LO hold old values throughout busy.
REQ-030 div A=-7, B=2 -> LO=32'hFFFF_FFFD(-3), HI=32'hFFFF_FFFF(-1).
REQ-031 mult running, start mtlo A=5 at busy=1 -> ignored; final LO equals product low word.
REQ-032 mthi A=32'h1234_5678 -> HI=32'h1234_5678 next cycle, busy stays 0.
REQ-033 rst_n=0 pulse at cycle 3 of div -> busy=0, HI=LO=0 immediately; no commit afterward.
